// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle RV32I datapath: sequences the shared-memory datapath and counts retired instructions.
// Optional build macro: ILLEGAL_TRAP_EN (illegal opcodes trap and hold the extra 'illegal' output).
module multicycle_ctrl #(
    parameter int unsigned WAIT_LIMIT = 15,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_ctrl,
    output logic [1:0]       result_src,
    output logic             pc_src,
    output logic             mem_err,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state_dbg
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic             illegal
`endif
);

    localparam int unsigned STALL_W = $clog2(WAIT_LIMIT + 1);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXEC_R  = 4'd6,
        EXEC_I  = 4'd7,
        ALU_WB  = 4'd8,
        BEQ     = 4'd9,
        JAL     = 4'd10,
        ILLEGAL = 4'd11,
        FAULT   = 4'd12
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [STALL_W-1:0] stall_cnt;
    logic               stall;
    logic               fault_hit;
    logic               retire;

    // funct3 -> ALU op; SUB only when the caller allows it (R-type)
    function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub_ok);
        logic [2:0] op;
        case (f3)
            3'b000:  op = sub_ok ? ALU_SUB : ALU_ADD;
            3'b111:  op = ALU_AND;
            3'b110:  op = ALU_OR;
            3'b100:  op = ALU_XOR;
            3'b010:  op = ALU_SLT;
            3'b001:  op = ALU_SLL;
            3'b101:  op = ALU_SRL;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    // Next-state and output decode
    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_ctrl   = ALU_ADD;
        result_src = 2'b00;
        pc_src     = 1'b0;
        retire     = 1'b0;
        stall      = 1'b0;
        fault_hit  = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        illegal    = 1'b0;
`endif
        case (state)
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b10;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_R:         state_next = EXEC_R;
                    OP_I:         state_next = EXEC_I;
                    OP_LW, OP_SW: state_next = MEMADR;
                    OP_BEQ:       state_next = BEQ;
                    OP_JAL:       state_next = JAL;
                    default:      state_next = ILLEGAL;
                endcase
            end
            EXEC_R: begin
                alu_src_a  = 2'b10;
                alu_ctrl   = alu_decode(funct3, funct7b5);
                state_next = ALU_WB;
            end
            EXEC_I: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                alu_ctrl   = alu_decode(funct3, 1'b0);
                state_next = ALU_WB;
            end
            ALU_WB: begin
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_next = FETCH;
            end
            MEMADR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                state_next = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_next = MEMWB;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                result_src = 2'b01;
                retire     = 1'b1;
                state_next = FETCH;
            end
            MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    retire     = 1'b1;
                    state_next = FETCH;
                end
            end
            BEQ: begin
                alu_src_a  = 2'b10;
                alu_ctrl   = ALU_SUB;
                pc_src     = 1'b1;
                pc_write   = zero;
                retire     = 1'b1;
                state_next = FETCH;
            end
            JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                reg_write  = 1'b1;
                pc_src     = 1'b1;
                pc_write   = 1'b1;
                retire     = 1'b1;
                state_next = FETCH;
            end
            ILLEGAL: begin
`ifdef ILLEGAL_TRAP_EN
                illegal    = 1'b1;
`else
                retire     = 1'b1;
                state_next = FETCH;
`endif
            end
            FAULT:   state_next = FAULT;
            default: state_next = FAULT;
        endcase

        // The stalled cycle that brings the count to WAIT_LIMIT faults instead of waiting again
        stall = mem_req & ~mem_ready;
        if (stall && (stall_cnt == STALL_W'(WAIT_LIMIT - 1))) begin
            fault_hit  = 1'b1;
            retire     = 1'b0;
            state_next = FAULT;
        end

        // Reset drops the in-flight instruction, so no write may escape in that cycle
        if (rst) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
            retire    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            retired   <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state <= state_next;
            if (retire) retired <= retired + CNT_W'(1);
            if (fault_hit) mem_err <= 1'b1;
            stall_cnt <= (stall && !fault_hit) ? stall_cnt + STALL_W'(1) : '0;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction cycle plans built from the instruction-level rules.
// Honors ILLEGAL_TRAP_EN to match the DUT build.
module tb_multicycle_ctrl;

    localparam logic [3:0] ST_FETCH = 4'd0;
    localparam logic [3:0] ST_FAULT = 4'd12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  opcode = '0;
    logic [2:0]  funct3 = '0;
    logic        funct7b5 = 1'b0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we, iord, ir_write, pc_write, reg_write, pc_src, mem_err;
    logic [1:0]  alu_src_a, alu_src_b, result_src;
    logic [2:0]  alu_ctrl;
    logic [31:0] retired;
    logic [3:0]  state_dbg;
`ifdef ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    multicycle_ctrl #(.WAIT_LIMIT(15), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
        .result_src(result_src), .pc_src(pc_src), .mem_err(mem_err), .retired(retired),
        .state_dbg(state_dbg)
`ifdef ILLEGAL_TRAP_EN
        , .illegal(illegal)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] o;
        logic        mem;
        logic        rdy;
        logic        ret;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
    } rec_t;

    rec_t        plan[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_retired = '0;

    function automatic logic [15:0] pk(input logic req, we, io, irw, pcw, rw,
                                       input logic [1:0] a, b, input logic [2:0] alu,
                                       input logic [1:0] rs, input logic ps);
        return {req, we, io, irw, pcw, rw, a, b, alu, rs, ps};
    endfunction

    function automatic logic [15:0] observed();
        return {mem_req, mem_we, iord, ir_write, pc_write, reg_write,
                alu_src_a, alu_src_b, alu_ctrl, result_src, pc_src};
    endfunction

    // Reference ALU selection from the instruction fields
    function automatic logic [2:0] exp_alu(input logic [2:0] f3, input logic sub);
        logic [2:0] t [8];
        t = '{3'd0, 3'd6, 3'd5, 3'd0, 3'd4, 3'd7, 3'd3, 3'd2};
        if (f3 == 3'b000 && sub) return 3'd1;
        return t[f3];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] o, input logic ret, input logic [6:0] op,
                        input logic [2:0] f3, input logic f7, input logic z);
        plan.push_back('{o: o, mem: 1'b0, rdy: 1'b0, ret: ret, op: op, f3: f3, f7: f7, z: z});
    endtask

    // w stalled cycles followed by the completing cycle
    task automatic push_mem(input logic [15:0] o_wait, input logic [15:0] o_done, input int w,
                            input logic ret, input logic [6:0] op, input logic [2:0] f3,
                            input logic f7, input logic z);
        for (int i = 0; i < w; i++)
            plan.push_back('{o: o_wait, mem: 1'b1, rdy: 1'b0, ret: 1'b0, op: op, f3: f3, f7: f7, z: z});
        plan.push_back('{o: o_done, mem: 1'b1, rdy: 1'b1, ret: ret, op: op, f3: f3, f7: f7, z: z});
    endtask

    task automatic add_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic z, input int wf, input int wm);
        push_mem(pk(1,0,0,0,0,0,2'd0,2'd2,3'd0,2'd0,0), pk(1,0,0,1,1,0,2'd0,2'd2,3'd0,2'd0,0),
                 wf, 1'b0, op, f3, f7, z);
        push(pk(0,0,0,0,0,0,2'd1,2'd1,3'd0,2'd0,0), 1'b0, op, f3, f7, z);
        case (op)
            7'b0110011: begin
                push(pk(0,0,0,0,0,0,2'd2,2'd0,exp_alu(f3, f7),2'd0,0), 1'b0, op, f3, f7, z);
                push(pk(0,0,0,0,0,1,2'd0,2'd0,3'd0,2'd0,0), 1'b1, op, f3, f7, z);
            end
            7'b0010011: begin
                push(pk(0,0,0,0,0,0,2'd2,2'd1,exp_alu(f3, 1'b0),2'd0,0), 1'b0, op, f3, f7, z);
                push(pk(0,0,0,0,0,1,2'd0,2'd0,3'd0,2'd0,0), 1'b1, op, f3, f7, z);
            end
            7'b0000011: begin
                push(pk(0,0,0,0,0,0,2'd2,2'd1,3'd0,2'd0,0), 1'b0, op, f3, f7, z);
                push_mem(pk(1,0,1,0,0,0,2'd0,2'd0,3'd0,2'd0,0), pk(1,0,1,0,0,0,2'd0,2'd0,3'd0,2'd0,0),
                         wm, 1'b0, op, f3, f7, z);
                push(pk(0,0,0,0,0,1,2'd0,2'd0,3'd0,2'd1,0), 1'b1, op, f3, f7, z);
            end
            7'b0100011: begin
                push(pk(0,0,0,0,0,0,2'd2,2'd1,3'd0,2'd0,0), 1'b0, op, f3, f7, z);
                push_mem(pk(1,1,1,0,0,0,2'd0,2'd0,3'd0,2'd0,0), pk(1,1,1,0,0,0,2'd0,2'd0,3'd0,2'd0,0),
                         wm, 1'b1, op, f3, f7, z);
            end
            7'b1100011: push(pk(0,0,0,0,z,0,2'd2,2'd0,3'd1,2'd0,1), 1'b1, op, f3, f7, z);
            7'b1101111: push(pk(0,0,0,0,1,1,2'd1,2'd2,3'd0,2'd2,1), 1'b1, op, f3, f7, z);
            default: begin
`ifndef ILLEGAL_TRAP_EN
                push(16'h0, 1'b1, op, f3, f7, z);
`endif
            end
        endcase
    endtask

    // Plays at most n planned cycles (n<0: all), checking outputs before each clock edge
    task automatic run_plan(input int n);
        int k = 0;
        while (plan.size() > 0 && (n < 0 || k < n)) begin
            rec_t r = plan.pop_front();
            @(negedge clk);
            opcode    = r.op;
            funct3    = r.f3;
            funct7b5  = r.f7;
            zero      = r.z;
            mem_ready = r.mem ? r.rdy : 1'($urandom_range(0, 1));
            #1;
            check("outputs", 64'(observed()), 64'(r.o));
            check("retired", 64'(retired), 64'(exp_retired));
            check("mem_err", 64'(mem_err), 64'd0);
            if (r.ret) exp_retired++;
            k++;
        end
        plan.delete();
    endtask

    // Holds rst n cycles, then releases into a stalled FETCH cycle
    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b1;
            mem_ready = 1'b1;
            #1;
            check("rst_writes", 64'({mem_we, ir_write, pc_write, reg_write, mem_req}), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b0;
        exp_retired = '0;
        #1;
        check("rst_state", 64'(state_dbg), 64'(ST_FETCH));
        check("rst_retired", 64'(retired), 64'd0);
        check("rst_mem_err", 64'(mem_err), 64'd0);
        check("rst_fetch_outs", 64'(observed()), 64'(pk(1,0,0,0,0,0,2'd0,2'd2,3'd0,2'd0,0)));
    endtask

    function automatic logic [6:0] rand_legal_op();
        logic [6:0] ops [6];
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111};
        return ops[$urandom_range(0, 5)];
    endfunction

    initial begin
        do_reset(2);

        // add / sub with zero-wait memory
        add_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0);
        run_plan(-1);
        add_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0);
        run_plan(-1);
        // lw with 3 wait cycles in MEMRD, I-type and sw at the last wait before timeout
        add_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 3);
        run_plan(-1);
        add_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0);
        run_plan(-1);
        add_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 14);
        run_plan(-1);
        add_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 14, 14);
        run_plan(-1);
        // beq taken / not taken, jal
        add_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0);
        run_plan(-1);
        add_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0);
        run_plan(-1);
        add_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0);
        run_plan(-1);

        // random legal instruction stream with random memory waits
        for (int i = 0; i < 60; i++) begin
            add_instr(rand_legal_op(), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
            run_plan(-1);
        end

        // reset in the writeback cycle drops the instruction
        add_instr(7'b0110011, 3'b111, 1'b0, 1'b0, 0, 0);
        run_plan(3);
        do_reset(1);

        // illegal opcode
`ifdef ILLEGAL_TRAP_EN
        add_instr(7'b0000000, 3'b000, 1'b0, 1'b0, 0, 0);
        run_plan(-1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            check("trap_illegal", 64'(illegal), 64'd1);
            check("trap_outs", 64'(observed()), 64'd0);
            check("trap_retired", 64'(retired), 64'(exp_retired));
        end
        do_reset(1);
        check("trap_cleared", 64'(illegal), 64'd0);
`else
        for (int i = 0; i < 4; i++) begin
            logic [6:0] op;
            op = (i == 0) ? 7'b0000000 : 7'($urandom_range(0, 127));
            while (op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 ||
                   op == 7'b0100011 || op == 7'b1100011 || op == 7'b1101111)
                op = 7'($urandom_range(0, 127));
            add_instr(op, 3'b000, 1'b0, 1'b0, 0, 0);
            run_plan(-1);
            add_instr(7'b0010011, 3'b100, 1'b0, 1'b0, 0, 0);
            run_plan(-1);
        end
`endif

        // memory timeout in FETCH: release cycle was stall 1, 14 more then FAULT
        do_reset(2);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            mem_ready = 1'b0;
            #1;
            check("stall_state", 64'(state_dbg), 64'(ST_FETCH));
            check("stall_mem_err", 64'(mem_err), 64'd0);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            check("fault_state", 64'(state_dbg), 64'(ST_FAULT));
            check("fault_mem_err", 64'(mem_err), 64'd1);
            check("fault_outs", 64'(observed()), 64'd0);
        end
        do_reset(2);
        add_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0);
        run_plan(-1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
